// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: FSM state encoding and width helper.
package mac_pkg;

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    OUT
  } mac_seq_state_t;

  function automatic int unsigned acc_w(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mac_seq.sv
// Sequencer that streams (activation, weight) pairs into an external registered MAC
// and returns the dot product. Optional MAC_SEQ_BIAS_EN adds bias_i as the first addend.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned LEN_W = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic signed [N-1:0]          s_value_i,
  input  logic signed [N-1:0]          s_weight_i,
  input  logic        [LEN_W-1:0]      len_i,
`ifdef MAC_SEQ_BIAS_EN
  input  logic signed [acc_w(N)-1:0]   bias_i,
`endif
  output logic                         mac_en_o,
  output logic signed [N-1:0]          mac_value_o,
  output logic signed [N-1:0]          mac_mult_o,
  output logic signed [acc_w(N)-1:0]   mac_add_o,
  input  logic signed [acc_w(N)-1:0]   mac_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic signed [acc_w(N)-1:0]   res_o
);

  localparam int unsigned ACC_W = acc_w(N);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef logic signed [N-1:0]     operand_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  mac_seq_state_t   state_q, state_d;
  logic             first_q, first_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             res_valid_q, res_valid_d;
  acc_t             res_q, res_d;

  logic [LEN_W-1:0] len_first;
  logic [LEN_W-1:0] eff_len;
  acc_t             first_add;
  logic             last_pair;

  // The first pair's own length must decide "last" in the same cycle it is latched.
  always_comb begin
    len_first = (len_i == '0) ? LEN_ONE : len_i;
    eff_len   = first_q ? len_first : len_q;
    last_pair = (count_q == (eff_len - LEN_ONE));
  end

`ifdef MAC_SEQ_BIAS_EN
  assign first_add = bias_i;
`else
  assign first_add = '0;
`endif

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    count_d     = count_q;
    len_d       = len_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    s_ready_o   = 1'b0;
    mac_en_o    = 1'b0;
    mac_value_o = operand_t'(s_value_i);
    mac_mult_o  = operand_t'(s_weight_i);
    mac_add_o   = first_q ? first_add : mac_i;

    unique case (state_q)
      ACC: begin
        s_ready_o = !rst_i;
        if (s_valid_i && !rst_i) begin
          mac_en_o = 1'b1;
          count_d  = count_q + LEN_ONE;
          first_d  = 1'b0;
          if (first_q) begin
            len_d = len_first;
          end
          if (last_pair) begin
            state_d = DRAIN;
            count_d = '0;
            first_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        res_d       = mac_i;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACC;
      first_q     <= 1'b1;
      count_q     <= '0;
      len_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      count_q     <= count_d;
      len_q       <= len_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;

endmodule
